run_detect_param: RTL and testbench
===================================

Name: run_detect_param

Overview:
Parametrised successor of the fixed 4-bit run detector. On a start strobe it captures the current sample as threshold, then evaluates a fixed window of NSAMP samples. It counts runs whose length reaches MIN_RUN and tracks the longest run, with selectable above/below comparison. It sits between the sample source and the host/status logic and reports results through a busy/done handshake.

Parameters:
DW, 8, sample and threshold width
MIN_RUN, 5, run length (consecutive hits) at which a run is counted; legal 1..NSAMP
NSAMP, 16, samples evaluated per window after capture; legal >= 2
CW, 8, width of run counter n_runs (saturating)
RW, $clog2(NSAMP+1), derived width of max_run; not overridden

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, synchronous, active-low
strt  input  1  start capture/compare; sampled only in IDLE
mode  input  1  0 = hit when sig > thres; 1 = hit when sig < thres; captured with strt
sig  input  DW  sample stream, one sample per clock
busy  output  1  high while window in progress
done  output  1  one-cycle pulse, results valid
thres  output  DW  captured threshold
n_runs  output  CW  number of qualifying runs in last window
max_run  output  RW  longest run of consecutive hits in last window

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE; busy=0, done=0, thres=0, n_runs=0, max_run=0; internal run_len=0, samp_cnt=0. Overrides everything. Reset mid-window aborts it: no done pulse, partial results discarded.
- FSM states are IDLE and CMP.
- IDLE, strt=1 at edge k:
  - thres<=sig, mode_q<=mode.
  - n_runs, max_run, run_len, samp_cnt <= 0.
  - Go to CMP; busy=1 from after edge k.
- IDLE, strt=0: hold all outputs.
- CMP:
  - Samples at edges k+1..k+NSAMP are evaluated, one per edge.
  - hit = (mode_q==0) ? sig>thres : sig<thres. Equality is never a hit. Compare is unsigned.
  - On hit: run_len<=run_len+1.
    - If run_len+1==MIN_RUN, n_runs increments, saturating at 2^CW-1.
    - If run_len+1>max_run, max_run<=run_len+1.
    - A run is counted exactly once, at the moment it reaches MIN_RUN, regardless of its final length.
  - On miss: run_len<=0.
  - samp_cnt increments each CMP cycle. On the edge where samp_cnt==NSAMP-1 (edge k+NSAMP), the last sample is evaluated, FSM returns to IDLE, busy<=0 and done<=1.
- done timing: high for exactly the cycle after edge k+NSAMP. Latency from strt edge to done high is NSAMP+1 edges. n_runs and max_run are final and stable in the done cycle.
- A run still open at window end counts only if it has already reached MIN_RUN.
- Outputs hold after done until the next accepted strt.
- strt during CMP is ignored; mode and sig changes do not affect thres during CMP.
- strt=1 in the done cycle (FSM is in IDLE) is accepted: new capture; n_runs and max_run clear at that edge; done deasserts.
- run_len never exceeds NSAMP; no wrap.
- thres is observable at all times.

Test Plan:
1. DW=8, MIN_RUN=5, NSAMP=16, mode=0, strt with sig=0x40. Window: 5x0x41, 0x10, 4x0x50, 0x00, 5x0x7F -> thres=0x40, n_runs=2, max_run=5, done pulses exactly 17 edges after strt edge, busy high for 16 cycles.
2. Same config, 16 consecutive samples 0xFF -> n_runs=1 (one run, counted once), max_run=16.
3. thres=0x40, all samples 0x40 with mode=0 -> n_runs=0, max_run=0. Repeat with mode=1 and all samples 0x3F -> n_runs=1, max_run=16.
4. Saturation: CW=2, MIN_RUN=1, NSAMP=16, alternating hit/miss starting with hit (8 runs) -> n_runs=3 (saturated), max_run=1.
5. Reset/abort:
   - rst_n low for one edge during sample 7 -> busy=0, all outputs 0, no done pulse.
   - Separately, strt pulsed mid-window -> ignored; thres unchanged; done still at edge k+17.
6. Back-to-back: strt=1 with sig=0x20 in the done cycle of a window ending with n_runs=2 -> thres=0x20, n_runs=0, max_run=0, busy=1 next cycle; second done 17 edges later.

Source files
------------

// File: rtl/run_detect_param.sv
// run_detect_param
//   Threshold run detector. A start strobe captures the current sample as
//   the threshold and latches the compare direction. The next NSAMP samples
//   are then compared against that threshold. The block counts runs of
//   consecutive hits that reach MIN_RUN and tracks the longest run. Results
//   are reported through a busy/done handshake.
//
//   Ports
//     clk      system clock; all state changes on the rising edge
//     rst_n    synchronous active-low reset
//     strt     start strobe; only sampled in IDLE
//     mode     0: hit when sig > thres, 1: hit when sig < thres (captured with strt)
//     sig      sample stream, one sample per clock
//     busy     high while a window is in progress
//     done     one-cycle pulse; n_runs/max_run are final while it is high
//     thres    captured threshold
//     n_runs   qualifying runs in the last window (saturating)
//     max_run  longest run of consecutive hits in the last window
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for strt; results of the previous window are held
//   CMP   | evaluating one sample per clock; NSAMP samples in total
module run_detect_param #(
  parameter int DW      = 8,
  parameter int MIN_RUN = 5,
  parameter int NSAMP   = 16,
  parameter int CW      = 8,
  parameter int RW      = $clog2(NSAMP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strt,
  input  logic          mode,
  input  logic [DW-1:0] sig,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] thres,
  output logic [CW-1:0] n_runs,
  output logic [RW-1:0] max_run
);

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  localparam logic [RW-1:0] RUN_QUAL = RW'(MIN_RUN);
  localparam logic [RW-1:0] LAST_CNT = RW'(NSAMP - 1);
  localparam logic [CW-1:0] NRUN_MAX = {CW{1'b1}};

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] thres_q, thres_d;
  logic [CW-1:0] n_runs_q, n_runs_d;
  logic [RW-1:0] max_run_q, max_run_d;
  logic [RW-1:0] run_len_q, run_len_d;
  logic [RW-1:0] samp_cnt_q, samp_cnt_d;

  logic          hit;
  logic [RW-1:0] run_nxt;

  // Equality is never a hit in either direction; compare is unsigned.
  assign hit = mode_q ? (sig < thres_q) : (sig > thres_q);

  // run_len is bounded by NSAMP, which RW is sized to hold, so no wrap.
  assign run_nxt = run_len_q + RW'(1);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    thres_d    = thres_q;
    n_runs_d   = n_runs_q;
    max_run_d  = max_run_q;
    run_len_d  = run_len_q;
    samp_cnt_d = samp_cnt_q;

    case (state_q)
      IDLE: begin
        if (strt) begin
          thres_d    = sig;
          mode_d     = mode;
          n_runs_d   = '0;
          max_run_d  = '0;
          run_len_d  = '0;
          samp_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = CMP;
        end
      end

      CMP: begin
        samp_cnt_d = samp_cnt_q + RW'(1);
        if (hit) begin
          run_len_d = run_nxt;
          // A run is counted once, at the moment it reaches the qualifying
          // length; longer runs do not count again.
          if (run_nxt == RUN_QUAL && n_runs_q != NRUN_MAX) begin
            n_runs_d = n_runs_q + CW'(1);
          end
          if (run_nxt > max_run_q) begin
            max_run_d = run_nxt;
          end
        end else begin
          run_len_d = '0;
        end

        if (samp_cnt_q == LAST_CNT) begin
          samp_cnt_d = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      thres_q    <= '0;
      n_runs_q   <= '0;
      max_run_q  <= '0;
      run_len_q  <= '0;
      samp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      thres_q    <= thres_d;
      n_runs_q   <= n_runs_d;
      max_run_q  <= max_run_d;
      run_len_q  <= run_len_d;
      samp_cnt_q <= samp_cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign thres   = thres_q;
  assign n_runs  = n_runs_q;
  assign max_run = max_run_q;

endmodule

// File: tb/tb_run_detect_param.sv
module tb_run_detect_param;

  localparam int DW    = 8;
  localparam int NSAMP = 16;
  localparam int MIN_A = 5;
  localparam int CW_A  = 8;
  localparam int MIN_B = 1;
  localparam int CW_B  = 2;
  localparam int RW    = $clog2(NSAMP + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          strt = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] sig = '0;

  logic            busy_a, done_a, busy_b, done_b;
  logic [DW-1:0]   thres_a, thres_b;
  logic [CW_A-1:0] n_runs_a;
  logic [CW_B-1:0] n_runs_b;
  logic [RW-1:0]   max_run_a, max_run_b;

  run_detect_param #(.DW(DW), .MIN_RUN(MIN_A), .NSAMP(NSAMP), .CW(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .strt(strt), .mode(mode), .sig(sig),
    .busy(busy_a), .done(done_a), .thres(thres_a), .n_runs(n_runs_a), .max_run(max_run_a)
  );

  run_detect_param #(.DW(DW), .MIN_RUN(MIN_B), .NSAMP(NSAMP), .CW(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .strt(strt), .mode(mode), .sig(sig),
    .busy(busy_b), .done(done_b), .thres(thres_b), .n_runs(n_runs_b), .max_run(max_run_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef logic [DW-1:0] win_t [NSAMP];
  typedef struct {
    logic [DW-1:0] th;
    int na, ma, nb, mb;
    int k;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: split the window into maximal runs of hits, then count the
  // runs at least minrun long and take the longest.
  function automatic void model(input bit m, input logic [DW-1:0] th, input win_t s,
                                input int minrun, input int cw, output int nr, output int mx);
    int runs[$];
    int cur;
    cur = 0;
    nr = 0;
    mx = 0;
    for (int i = 0; i < NSAMP; i++) begin
      bit h;
      h = m ? (s[i] < th) : (s[i] > th);
      if (h) cur++;
      else begin
        if (cur > 0) runs.push_back(cur);
        cur = 0;
      end
    end
    if (cur > 0) runs.push_back(cur);
    foreach (runs[j]) begin
      if (runs[j] >= minrun) nr++;
      if (runs[j] > mx) mx = runs[j];
    end
    if (nr > (1 << cw) - 1) nr = (1 << cw) - 1;
  endfunction

  // Issues one window. The strt of the next call lands in the done cycle of
  // this one, so consecutive calls exercise back-to-back windows.
  task automatic run_window(input bit m, input logic [DW-1:0] th, input win_t s,
                            input int mid_strt_at, input int abort_at);
    exp_t e;
    @(negedge clk);
    if (abort_at < 0) begin
      model(m, th, s, MIN_A, CW_A, e.na, e.ma);
      model(m, th, s, MIN_B, CW_B, e.nb, e.mb);
      e.th = th;
      e.k  = cyc + 1;
      sb.push_back(e);
    end
    strt = 1'b1;
    mode = m;
    sig  = th;
    @(negedge clk);
    chk("busy_after_strt", busy_a, 1);
    chk("thres_after_strt", thres_a, th);
    chk("n_runs_cleared", n_runs_a, 0);
    chk("max_run_cleared", max_run_a, 0);
    chk("busy_b_after_strt", busy_b, 1);
    for (int i = 0; i < NSAMP; i++) begin
      if (i > 0) @(negedge clk);
      strt = (i == mid_strt_at);
      mode = 1'($urandom);
      sig  = s[i];
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        strt  = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_thres", thres_a, 0);
        chk("abort_n_runs", n_runs_a, 0);
        chk("abort_max_run", max_run_a, 0);
        chk("abort_busy_b", busy_b, 0);
        chk("abort_n_runs_b", n_runs_b, 0);
        repeat (NSAMP + 3) @(negedge clk);
        return;
      end
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  bit prev_done = 1'b0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (busy_a) busy_cnt++;
    else if (!done_a) busy_cnt = 0;
    if (done_a) begin
      chk("done_single_pulse", prev_done, 0);
      chk("busy_cycles", busy_cnt, NSAMP);
      chk("done_b_aligned", done_b, 1);
      busy_cnt = 0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc, e.k + NSAMP);
        chk("thres", thres_a, e.th);
        chk("n_runs", n_runs_a, e.na);
        chk("max_run", max_run_a, e.ma);
        chk("busy_in_done", busy_a, 0);
        chk("thres_b", thres_b, e.th);
        chk("n_runs_sat", n_runs_b, e.nb);
        chk("max_run_b", max_run_b, e.mb);
      end
    end else if (done_b) begin
      chk("done_b_aligned", done_b, 0);
    end
    prev_done = done_a;
  end

  initial begin
    win_t s;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_thres", thres_a, 0);
    chk("rst_n_runs", n_runs_a, 0);
    chk("rst_max_run", max_run_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mixed pattern: two qualifying runs, longest 5.
    for (int i = 0; i < 5; i++) s[i] = 8'h41;
    s[5] = 8'h10;
    for (int i = 6; i < 10; i++) s[i] = 8'h50;
    s[10] = 8'h00;
    for (int i = 11; i < 16; i++) s[i] = 8'h7F;
    run_window(1'b0, 8'h40, s, -1, -1);

    // Back-to-back capture with thres 0x20 in the done cycle: all hits.
    for (int i = 0; i < NSAMP; i++) s[i] = 8'hFF;
    run_window(1'b0, 8'h20, s, -1, -1);

    // Equality never hits, in either mode.
    for (int i = 0; i < NSAMP; i++) s[i] = 8'h40;
    run_window(1'b0, 8'h40, s, -1, -1);
    run_window(1'b1, 8'h40, s, -1, -1);
    for (int i = 0; i < NSAMP; i++) s[i] = 8'h3F;
    run_window(1'b1, 8'h40, s, -1, -1);

    // Alternating hit/miss: eight single-sample runs, saturates the CW=2 counter.
    for (int i = 0; i < NSAMP; i++) s[i] = (i % 2 == 0) ? 8'h41 : 8'h40;
    run_window(1'b0, 8'h40, s, -1, -1);

    // strt mid-window is ignored.
    for (int i = 0; i < NSAMP; i++) s[i] = (i < 9) ? 8'h90 : 8'h05;
    run_window(1'b0, 8'h30, s, 5, -1);

    // Reset during the seventh sample aborts the window.
    run_window(1'b0, 8'h30, s, -1, 6);

    for (int w = 0; w < 40; w++) begin
      logic [DW-1:0] th;
      th = 8'($urandom_range(4, 251));
      for (int i = 0; i < NSAMP; i++) s[i] = 8'(int'(th) + int'($urandom_range(0, 6)) - 3);
      if ($urandom_range(0, 3) == 0) begin
        strt = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      run_window(1'($urandom), th, s, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NSAMP - 1)) : -1, -1);
    end

    strt = 1'b0;
    repeat (NSAMP + 4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
